// File: rtl/ad_pkg.sv
// rtl/ad_pkg.sv - shared state encoding and default widths for the ADC sample-window generator
package ad_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    SAMPLE = 2'd2,
    DRAIN  = 2'd3
  } ad_state_t;

  localparam int AD_CNT_W   = 16;
  localparam int AD_ADC_LAT = 5;
  localparam int AD_AVG_W   = 8;

endpackage

// File: rtl/ad_valid_pipe.sv
// rtl/ad_valid_pipe.sv - ADC_LAT-stage delay line carrying {en, idx, first, last}
module ad_valid_pipe #(
  parameter int CNT_W   = 16,
  parameter int ADC_LAT = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_idx,
  input  logic             i_first,
  input  logic             i_last,
  output logic             o_en,
  output logic [CNT_W-1:0] o_idx,
  output logic             o_first,
  output logic             o_last
);

  logic             r_en    [ADC_LAT];
  logic             r_first [ADC_LAT];
  logic             r_last  [ADC_LAT];
  logic [CNT_W-1:0] r_idx   [ADC_LAT];

  // idx only advances alongside a valid bit, so the tap holds the last valid index
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < ADC_LAT; k++) begin
        r_en[k]    <= 1'b0;
        r_first[k] <= 1'b0;
        r_last[k]  <= 1'b0;
        r_idx[k]   <= '0;
      end
    end else begin
      r_en[0]    <= i_en;
      r_first[0] <= i_first;
      r_last[0]  <= i_last;
      if (i_en) r_idx[0] <= i_idx;
      for (int k = 1; k < ADC_LAT; k++) begin
        r_en[k]    <= r_en[k-1];
        r_first[k] <= r_first[k-1];
        r_last[k]  <= r_last[k-1];
        if (r_en[k-1]) r_idx[k] <= r_idx[k-1];
      end
    end
  end

  assign o_en    = r_en[ADC_LAT-1];
  assign o_idx   = r_idx[ADC_LAT-1];
  assign o_first = r_first[ADC_LAT-1];
  assign o_last  = r_last[ADC_LAT-1];

endmodule

// File: rtl/ad_window_gen.sv
// rtl/ad_window_gen.sv - burst-triggered ADC sample window with latency-aligned valid, markers and frame counting
module ad_window_gen
  import ad_pkg::*;
#(
  parameter int CNT_W   = AD_CNT_W,
  parameter int AVG_W   = AD_AVG_W,
  parameter int ADC_LAT = AD_ADC_LAT
) (
  input  logic             clk_sample,
  input  logic             reset,
  input  logic             burst_syn,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [AVG_W-1:0] cfg_avg,
  input  logic             sink_full,
  output logic             AD_sample_en,
  output logic             AD_data_valid,
  output logic [CNT_W-1:0] sample_idx,
  output logic             first_sample,
  output logic             last_sample,
  output logic [AVG_W-1:0] burst_idx,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ADC_LAT - 1);

  ad_state_t        r_state, w_state_nxt;
  logic             r_burst_q;
  logic [CNT_W-1:0] r_cnt, r_delay, r_len;
  logic [AVG_W-1:0] r_avg, r_burst_idx;
  logic             r_frame_done, r_overrun;
  logic             w_trig, w_accept, w_drop, w_cnt_clr, w_done;
  logic             w_sampling, w_first, w_last;

  assign w_trig = burst_syn & ~r_burst_q;

  always_ff @(posedge clk_sample or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_done      = 1'b0;
    if (r_state != IDLE) w_drop = w_trig;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          if (sink_full) begin
            w_drop = 1'b1;
          end else if (cfg_len != '0) begin
            w_accept    = 1'b1;
            w_state_nxt = (cfg_delay != '0) ? DELAY : SAMPLE;
          end
        end
      end
      DELAY: begin
        if (r_cnt == r_delay - 1'b1) begin
          w_state_nxt = SAMPLE;
          w_cnt_clr   = 1'b1;
        end
      end
      SAMPLE: begin
        if (r_cnt == r_len - 1'b1) begin
          w_state_nxt = DRAIN;
          w_cnt_clr   = 1'b1;
        end
      end
      DRAIN: begin
        if (r_cnt == LAT_M1) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sample or posedge reset) begin
    if (reset) begin
      r_burst_q    <= 1'b0;
      r_cnt        <= '0;
      r_delay      <= '0;
      r_len        <= '0;
      r_avg        <= '0;
      r_burst_idx  <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_burst_q    <= burst_syn;
      r_overrun    <= w_drop;
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_delay <= cfg_delay;
        r_len   <= cfg_len;
        r_avg   <= (cfg_avg == '0) ? AVG_W'(1) : cfg_avg;
      end
      if (w_accept || w_cnt_clr) r_cnt <= '0;
      else if (r_state != IDLE)  r_cnt <= r_cnt + 1'b1;
      // >= rather than == so a count left over from a larger frame still wraps
      if (w_done) begin
        if (({1'b0, r_burst_idx} + 1'b1) >= {1'b0, r_avg}) begin
          r_burst_idx  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_burst_idx <= r_burst_idx + 1'b1;
        end
      end
    end
  end

  assign w_sampling = (r_state == SAMPLE);
  assign w_first    = w_sampling && (r_cnt == '0);
  assign w_last     = w_sampling && (r_cnt == r_len - 1'b1);

  ad_valid_pipe #(
    .CNT_W  (CNT_W),
    .ADC_LAT(ADC_LAT)
  ) u_valid_pipe (
    .i_clk  (clk_sample),
    .i_rst  (reset),
    .i_en   (w_sampling),
    .i_idx  (r_cnt),
    .i_first(w_first),
    .i_last (w_last),
    .o_en   (AD_data_valid),
    .o_idx  (sample_idx),
    .o_first(first_sample),
    .o_last (last_sample)
  );

  assign AD_sample_en = w_sampling;
  assign busy         = (r_state != IDLE);
  assign burst_idx    = r_burst_idx;
  assign frame_done   = r_frame_done;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_ad_window_gen.sv
// tb/tb_ad_window_gen.sv - directed self-checking bench for ad_window_gen
module tb_ad_window_gen;

  localparam int CNT_W   = 16;
  localparam int AVG_W   = 8;
  localparam int ADC_LAT = 5;

  logic             clk_sample = 1'b0;
  logic             reset;
  logic             burst_syn;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_len;
  logic [AVG_W-1:0] cfg_avg;
  logic             sink_full;
  logic             AD_sample_en;
  logic             AD_data_valid;
  logic [CNT_W-1:0] sample_idx;
  logic             first_sample;
  logic             last_sample;
  logic [AVG_W-1:0] burst_idx;
  logic             frame_done;
  logic             busy;
  logic             overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sample = ~clk_sample;

  ad_window_gen #(
    .CNT_W  (CNT_W),
    .AVG_W  (AVG_W),
    .ADC_LAT(ADC_LAT)
  ) dut (
    .clk_sample   (clk_sample),
    .reset        (reset),
    .burst_syn    (burst_syn),
    .cfg_delay    (cfg_delay),
    .cfg_len      (cfg_len),
    .cfg_avg      (cfg_avg),
    .sink_full    (sink_full),
    .AD_sample_en (AD_sample_en),
    .AD_data_valid(AD_data_valid),
    .sample_idx   (sample_idx),
    .first_sample (first_sample),
    .last_sample  (last_sample),
    .burst_idx    (burst_idx),
    .frame_done   (frame_done),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic test_reset();
    logic [6:0] got;
    reset     = 1'b1;
    burst_syn = 1'b0;
    cfg_delay = '0;
    cfg_len   = '0;
    cfg_avg   = 8'd1;
    sink_full = 1'b0;
    repeat (3) @(negedge clk_sample);
    for (int p = 0; p < 2; p++) begin
      got = {AD_sample_en, AD_data_valid, first_sample, last_sample, frame_done, busy, overrun};
      n_cmp++;
      if (got !== 7'b0 || sample_idx !== '0 || burst_idx !== '0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: flags=%b idx=%0d bidx=%0d, want 0/0/0", p, got, sample_idx, burst_idx);
      end
      reset = 1'b0;
      @(negedge clk_sample);
    end
  endtask

  // single burst with cfg_avg=1; k counts negedges after trigger edge E0
  task automatic test_window(input int d, input int l, input string tag);
    logic [6:0] got, exp;
    int         t_end;
    t_end     = d + l + ADC_LAT;
    cfg_delay = CNT_W'(d);
    cfg_len   = CNT_W'(l);
    cfg_avg   = 8'd1;
    burst_syn = 1'b1;
    for (int k = 0; k < t_end + 4; k++) begin
      @(negedge clk_sample);
      if (k == 0) burst_syn = 1'b0;
      if (k == 1) begin
        cfg_len   = 16'd50;
        cfg_delay = 16'd9;
      end
      exp = {(k >= d && k < d + l),
             (k >= d + ADC_LAT && k < t_end),
             (k == d + ADC_LAT),
             (k == t_end - 1),
             (k == t_end),
             (k < t_end),
             1'b0};
      got = {AD_sample_en, AD_data_valid, first_sample, last_sample, frame_done, busy, overrun};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s_flags k=%0d: got %b want %b", tag, k, got, exp);
      end
      if (exp[5] || k >= t_end) begin
        n_cmp++;
        if (sample_idx !== CNT_W'(exp[5] ? k - d - ADC_LAT : l - 1)) begin
          n_bad++;
          $display("FAIL %s_idx k=%0d: got %0d", tag, k, sample_idx);
        end
      end
    end
  endtask

  task automatic test_avg_frames();
    int exp_bidx [4] = '{1, 2, 0, 1};
    cfg_delay = '0;
    for (int b = 0; b < 4; b++) begin
      cfg_len   = 16'd8;
      cfg_avg   = 8'd3;
      burst_syn = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk_sample);
        if (k == 0) burst_syn = 1'b0;
        if (k == 1) begin
          cfg_len = 16'd2;
          cfg_avg = 8'd0;
        end
        n_cmp++;
        if ({AD_sample_en, frame_done} !== {(k < 8), (k == 13 && b == 2)}) begin
          n_bad++;
          $display("FAIL avg_flags b=%0d k=%0d: got en=%b fd=%b", b, k, AD_sample_en, frame_done);
        end
        if (k == 13) begin
          n_cmp++;
          if (burst_idx !== AVG_W'(exp_bidx[b])) begin
            n_bad++;
            $display("FAIL avg_burst_idx b=%0d: got %0d want %0d", b, burst_idx, exp_bidx[b]);
          end
        end
      end
    end
  endtask

  // burst_idx enters at 1; cfg_avg=4 so the one accepted burst lands it on 2
  task automatic test_overrun();
    logic [3:0] got, exp;
    cfg_delay = '0;
    cfg_len   = 16'd8;
    cfg_avg   = 8'd4;
    burst_syn = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk_sample);
      exp = {(k < 8), (k == 4 || k == 21), 1'b0, (k < 13)};
      got = {AD_sample_en, overrun, frame_done, busy};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL overrun_flags k=%0d: got %b want %b", k, got, exp);
      end
      case (k)
        0:  burst_syn = 1'b0;
        3:  burst_syn = 1'b1;
        4:  burst_syn = 1'b0;
        20: begin
          sink_full = 1'b1;
          burst_syn = 1'b1;
        end
        21: burst_syn = 1'b0;
        22: sink_full = 1'b0;
        default: ;
      endcase
    end
    n_cmp++;
    if (burst_idx !== 8'd2) begin
      n_bad++;
      $display("FAIL overrun_burst_idx: got %0d want 2", burst_idx);
    end
  endtask

  task automatic test_mid_reset();
    logic [6:0] got;
    int         n_valid;
    cfg_delay = '0;
    cfg_len   = 16'd8;
    cfg_avg   = 8'd1;
    burst_syn = 1'b1;
    repeat (4) @(negedge clk_sample);
    burst_syn = 1'b0;
    reset     = 1'b1;
    #1;
    for (int p = 0; p < 3; p++) begin
      got = {AD_sample_en, AD_data_valid, first_sample, last_sample, frame_done, busy, overrun};
      n_cmp++;
      if (got !== 7'b0 || sample_idx !== '0 || burst_idx !== '0) begin
        n_bad++;
        $display("FAIL midreset_outputs p=%0d: flags=%b idx=%0d bidx=%0d", p, got, sample_idx, burst_idx);
      end
      @(negedge clk_sample);
    end
    reset   = 1'b0;
    n_valid = 0;
    repeat (15) begin
      @(negedge clk_sample);
      if (AD_data_valid || AD_sample_en) n_valid++;
    end
    n_cmp++;
    if (n_valid != 0) begin
      n_bad++;
      $display("FAIL midreset_stray_valid: got %0d cycles want 0", n_valid);
    end
    burst_syn = 1'b1;
    repeat (6) @(negedge clk_sample);
    burst_syn = 1'b0;
    n_cmp++;
    if ({AD_data_valid, first_sample, sample_idx} !== {1'b1, 1'b1, 16'd0}) begin
      n_bad++;
      $display("FAIL midreset_restart: got v=%b f=%b idx=%0d want 1/1/0", AD_data_valid, first_sample, sample_idx);
    end
    repeat (12) @(negedge clk_sample);
  endtask

  task automatic test_held_high();
    int n_en, n_ovr, n_busy, first_k;
    cfg_delay = '0;
    cfg_len   = '0;
    cfg_avg   = 8'd1;
    burst_syn = 1'b1;
    n_en      = 0;
    n_ovr     = 0;
    n_busy    = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_sample);
      if (i == 100) cfg_len = 16'd4;
      if (AD_sample_en) n_en++;
      if (overrun) n_ovr++;
      if (busy) n_busy++;
    end
    n_cmp++;
    if ({n_en, n_ovr, n_busy} !== {32'd0, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL held_no_retrigger: en=%0d ovr=%0d busy=%0d want 0/0/0", n_en, n_ovr, n_busy);
    end
    burst_syn = 1'b0;
    @(negedge clk_sample);
    burst_syn = 1'b1;
    first_k   = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_sample);
      if (AD_sample_en) begin
        n_en++;
        if (first_k < 0) first_k = k;
      end
    end
    n_cmp++;
    if (n_en != 4 || first_k != 0) begin
      n_bad++;
      $display("FAIL held_window: got %0d cycles from k=%0d want 4 from k=0", n_en, first_k);
    end
    burst_syn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_window(0, 8, "basic_d0_l8");
    test_window(3, 1, "d3_l1");
    test_avg_frames();
    test_overrun();
    test_mid_reset();
    test_held_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
